// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART TX scheduler slice.
//   - FSM state type
//   - Ucr control bit indices and common control encodings
//   - Usr status field positions
//   - FIFO count display helper
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  // Ucr bit indices
  localparam int unsigned UCR_EN      = 0;
  localparam int unsigned UCR_CLR     = 2;
  localparam int unsigned UCR_IRQ_MSK = 3;

  // Usr field positions
  localparam int unsigned USR_DONE_LSB = 0;  // [1:0] frame complete (sticky)
  localparam int unsigned USR_FULL     = 2;
  localparam int unsigned USR_EMPTY    = 3;
  localparam int unsigned USR_BUSY     = 4;
  localparam int unsigned USR_CNT_LSB  = 5;  // [7:5] FIFO count
  localparam int unsigned USR_FRM_LSB  = 8;  // [15:8] frames sent

  // Common Ucr encodings
  localparam logic [15:0] UCR_TX_EN     = 16'h0001;
  localparam logic [15:0] UCR_TX_EN_CLR = 16'h0005;

  // FIFO count as shown in Usr[7:5]: saturates at 7
  function automatic logic [2:0] sat_count(input logic [3:0] n);
    return (n > 4'd7) ? 3'd7 : n[2:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO for the UART TX scheduler.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties FIFO)
//   push, push_data   write request and data (ignored when full)
//   pop               read request (ignored when empty)
//   head              current head entry (valid when !empty)
//   full, empty       status flags
//   count             number of stored entries
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbitration of two byte requesters into a
// TX FIFO, and load/shift sequencing of the UART PISO, one frame per byte.
// Optional feature macro: UART_TX_IRQ_EN (adds registered Tx_Irq output).
// Ports:
//   Clk, Rst                    clock, asynchronous active-high reset
//   Ucr[15:0]                   control: [0] TX enable, [2] status clear, [3] irq mask
//   Req0_Valid/Data/Ready       requester 0 handshake (Ready combinational)
//   Req1_Valid/Data/Ready       requester 1 handshake
//   Piso_Data[7:0]              byte for the PISO, stable for the frame
//   Piso_Load                   one-cycle load strobe
//   Piso_Shift                  one strobe per bit period
//   Usr[15:0]                   status register
//   Tx_Irq                      (UART_TX_IRQ_EN only) Usr[0] & Ucr[3], registered
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Ucr,
  input  logic        Req0_Valid,
  input  logic [7:0]  Req0_Data,
  output logic        Req0_Ready,
  input  logic        Req1_Valid,
  input  logic [7:0]  Req1_Data,
  output logic        Req1_Ready,
  output logic [7:0]  Piso_Data,
  output logic        Piso_Load,
  output logic        Piso_Shift,
  output logic [15:0] Usr
`ifdef UART_TX_IRQ_EN
  ,
  output logic        Tx_Irq
`endif
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned NW = $clog2(FRAME_BITS + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [NW-1:0] bit_cnt;
  logic          baud_wrap;

  logic          last_grant;   // 1: Req1 was granted last
  logic          sel1;
  logic          push;
  logic [7:0]    push_data;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;

  logic [1:0]    done_flags;
  logic [7:0]    frames;
  logic          unused_ucr;

  // ---------------- Arbitration ----------------
  always_comb begin
    sel1 = Req1_Valid;
    if (Req0_Valid && Req1_Valid)
      sel1 = ~last_grant;
  end

  assign Req0_Ready = Req0_Valid & ~sel1 & ~full;
  assign Req1_Ready = Req1_Valid &  sel1 & ~full;
  assign push       = (Req0_Valid & Req0_Ready) | (Req1_Valid & Req1_Ready);
  assign push_data  = sel1 ? Req1_Data : Req0_Data;

  // Reset to "Req1 last" so Req0 wins the first contention.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      last_grant <= 1'b1;
    else if (push)
      last_grant <= sel1;
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // ---------------- Frame sequencer ----------------
  assign pop       = (state == ST_IDLE) & Ucr[UCR_EN] & ~empty;
  assign baud_wrap = (baud_cnt == BW'(CLK_DIV - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      Piso_Data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            Piso_Data <= head;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + NW'(1);
            if (bit_cnt == NW'(FRAME_BITS - 1))
              state <= ST_DONE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= ST_IDLE;  // ST_DONE
      endcase
    end
  end

  // Strobes decode the registered state, so Rst drops them immediately.
  assign Piso_Load  = (state == ST_LOAD);
  assign Piso_Shift = (state == ST_SHIFT) & baud_wrap;

  // ---------------- Status ----------------
  // Completion takes priority over a concurrent clear: the counter restarts at 1.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      done_flags <= '0;
      frames     <= '0;
    end else if (state == ST_DONE) begin
      done_flags <= '1;
      frames     <= Ucr[UCR_CLR] ? 8'd1 : frames + 8'd1;
    end else if (Ucr[UCR_CLR]) begin
      done_flags <= '0;
      frames     <= '0;
    end
  end

  always_comb begin
    Usr                       = '0;
    Usr[USR_DONE_LSB +: 2]    = done_flags;
    Usr[USR_FULL]             = full;
    Usr[USR_EMPTY]            = empty;
    Usr[USR_BUSY]             = (state != ST_IDLE);
    Usr[USR_CNT_LSB +: 3]     = sat_count(4'(fifo_count));
    Usr[USR_FRM_LSB +: 8]     = frames;
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      Tx_Irq <= 1'b0;
    else
      Tx_Irq <= done_flags[0] & Ucr[UCR_IRQ_MSK];
  end
`endif

  assign unused_ucr = ^Ucr;

endmodule
